// File: rtl/execute_stage_md.sv
// Execute stage: operand forwarding, ALU, branch resolution, an iterative unsigned
// multiply/divide unit (one bit per cycle) and the EX/MEM pipeline register.
module execute_stage_md #(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_e,
  input  logic            flush_e,
  input  logic            branch_e,
  input  logic [2:0]      br_funct_e,
  input  logic            alu_src_e,
  input  logic            reg_write_e,
  input  logic            result_src_e,
  input  logic            mem_write_e,
  input  logic            md_en_e,
  input  logic [1:0]      md_op_e,
  input  logic [3:0]      alu_ctrl_e,
  input  logic [4:0]      rd_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [XLEN-1:0] alu_result_m_in,
  input  logic [XLEN-1:0] result_w_in,
  input  logic [1:0]      fwd_a_e,
  input  logic [1:0]      fwd_b_e,
  output logic            stall_e,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            reg_write_m,
  output logic            result_src_m,
  output logic            mem_write_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [4:0]      rd_m,
  output logic [1:0]      dbg_md_state
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} md_state_t;

  md_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [1:0]      r_op;
  logic [4:0]      r_rd;
  logic            r_rw;

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [CW-1:0]   w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_cond;
  logic            w_accept;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_shift;
  logic [XLEN:0]   w_div_diff;
  logic [XLEN-1:0] w_md_res;

  always_comb begin
    w_fwd_a = rd1_e;
    case (fwd_a_e)
      2'b01:   w_fwd_a = result_w_in;
      2'b10:   w_fwd_a = alu_result_m_in;
      default: w_fwd_a = rd1_e;
    endcase
    w_fwd_b = rd2_e;
    case (fwd_b_e)
      2'b01:   w_fwd_b = result_w_in;
      2'b10:   w_fwd_b = alu_result_m_in;
      default: w_fwd_b = rd2_e;
    endcase
  end

  assign w_src_b = alu_src_e ? imm_e : w_fwd_b;
  assign w_shamt = w_src_b[CW-1:0];

  always_comb begin
    w_alu = '0;
    case (alu_ctrl_e)
      4'h0:    w_alu = w_fwd_a + w_src_b;
      4'h1:    w_alu = w_fwd_a - w_src_b;
      4'h2:    w_alu = w_fwd_a & w_src_b;
      4'h3:    w_alu = w_fwd_a | w_src_b;
      4'h4:    w_alu = w_fwd_a ^ w_src_b;
      4'h5:    w_alu = {{(XLEN-1){1'b0}}, $signed(w_fwd_a) < $signed(w_src_b)};
      4'h6:    w_alu = {{(XLEN-1){1'b0}}, w_fwd_a < w_src_b};
      4'h7:    w_alu = w_fwd_a << w_shamt;
      4'h8:    w_alu = w_fwd_a >> w_shamt;
      4'h9:    w_alu = $unsigned($signed(w_fwd_a) >>> w_shamt);
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (br_funct_e)
      3'b000:  w_cond = (w_fwd_a == w_fwd_b);
      3'b001:  w_cond = (w_fwd_a != w_fwd_b);
      3'b100:  w_cond = ($signed(w_fwd_a) < $signed(w_fwd_b));
      3'b101:  w_cond = ($signed(w_fwd_a) >= $signed(w_fwd_b));
      3'b110:  w_cond = (w_fwd_a < w_fwd_b);
      3'b111:  w_cond = (w_fwd_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign pc_target_e = pc_e + imm_e;
  assign pc_src_e    = valid_e & branch_e & ~flush_e & w_cond;

  // Handshake: stall_e=1 tells upstream to hold ID/EX; it is raised for the
  // accepting IDLE cycle and every BUSY cycle, and dropped in DONE.
  assign w_accept     = (MD_EN != 0) && (r_state == S_IDLE) && valid_e && md_en_e && !flush_e;
  assign stall_e      = w_accept || (r_state == S_BUSY);
  assign dbg_md_state = r_state;

  // Shift-add multiply on {hi,lo}; restoring divide with hi as remainder, lo as quotient.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_md_res    = r_op[0] ? r_hi : r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_rw    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hi    <= '0;
            r_lo    <= w_fwd_a;
            r_b     <= w_fwd_b;
            r_op    <= md_op_e;
            r_rd    <= rd_e;
            r_rw    <= reg_write_e;
            r_cnt   <= CW'(XLEN - 1);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush_e) begin
            r_state <= S_IDLE;
          end else begin
            if (r_op[1]) begin
              if (!w_div_diff[XLEN]) begin
                r_hi <= w_div_diff[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], 1'b1};
              end else begin
                r_hi <= w_div_shift[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], 1'b0};
              end
            end else begin
              r_hi <= w_mul_sum[XLEN:1];
              r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      result_src_m <= 1'b0;
      mem_write_m  <= 1'b0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
    end else if (r_state == S_DONE) begin
      reg_write_m  <= r_rw;
      result_src_m <= 1'b0;
      mem_write_m  <= 1'b0;
      alu_result_m <= w_md_res;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= r_rd;
    end else if (stall_e || flush_e || !valid_e) begin
      reg_write_m  <= 1'b0;
      result_src_m <= 1'b0;
      mem_write_m  <= 1'b0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
    end else begin
      reg_write_m  <= reg_write_e;
      result_src_m <= result_src_e;
      mem_write_m  <= mem_write_e;
      alu_result_m <= w_alu;
      write_data_m <= w_fwd_b;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
    end
  end

endmodule

// File: doc/execute_stage_md.md
EXECUTE_STAGE_MD -- requirements
Module: execute_stage_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (even, >=8).
REQ-002 SHALL have parameter MD_EN, default 1; when 0 the multiply/divide unit is absent and md_en_e is ignored.
REQ-003 SHALL use clock clk and reset rst (asynchronous, active-high); ports in order: clk in 1, rst in 1.
REQ-004 SHALL have inputs valid_e 1, flush_e 1, branch_e 1, br_funct_e 3, alu_src_e 1, reg_write_e 1, result_src_e 1, mem_write_e 1, md_en_e 1, md_op_e 2, alu_ctrl_e 4, and rd_e 5.
REQ-005 SHALL have inputs rd1_e, rd2_e, pc_e, imm_e, pc_plus4_e, alu_result_m_in and result_w_in, each XLEN wide; fwd_a_e 2 and fwd_b_e 2.
REQ-006 SHALL have outputs stall_e 1, pc_src_e 1, pc_target_e XLEN, reg_write_m 1, result_src_m 1, mem_write_m 1, alu_result_m XLEN, write_data_m XLEN, pc_plus4_m XLEN, and rd_m 5.

Function
REQ-007 Forward muxes SHALL select rd1_e/rd2_e on 00, result_w_in on 01, alu_result_m_in on 10, and rd1_e/rd2_e on 11.
REQ-008 SrcB SHALL be imm_e if alu_src_e=1, else forwarded B; write data SHALL always be forwarded B.
REQ-009 ALU SHALL support these ops (modulo 2^XLEN; shift amount = low log2(XLEN) bits of SrcB): 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT signed, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA; all other codes SHALL give 0.
REQ-010 pc_target_e SHALL equal pc_e+imm_e mod 2^XLEN, combinationally.
REQ-011 pc_src_e SHALL equal valid_e & branch_e & ~flush_e & cond, with cond on br_funct_e: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU, others 0 -- comparing forwarded A vs forwarded B.
REQ-012 The MD FSM SHALL have states IDLE, BUSY, DONE; md_op_e: 00 MUL low XLEN, 01 MULHU high XLEN, 10 DIVU, 11 REMU, all unsigned, iterative one bit per cycle.
REQ-013 In IDLE with valid_e & md_en_e & ~flush_e, the FSM SHALL latch forwarded A/B, md_op_e, rd_e and reg_write_e, and go to BUSY with counter=XLEN-1.
REQ-014 BUSY SHALL decrement the counter each cycle and go to DONE after the counter=0 cycle (XLEN BUSY cycles); DONE SHALL return to IDLE after one cycle.
REQ-015 stall_e SHALL be combinationally 1 during the accepting IDLE cycle and all BUSY cycles, and 0 in DONE; upstream holds ID/EX while stall_e=1.
REQ-016 An MD instruction SHALL therefore hold stall_e high for XLEN+1 cycles, with its result written into EX/MEM at the end of DONE.
REQ-017 Divide by zero SHALL give quotient all-ones and remainder = dividend, without early exit.
REQ-018 EX/MEM SHALL register all *_m outputs each cycle; valid non-MD instructions load ALU result, write data, pc_plus4_e, rd_e and controls.
REQ-019 EX/MEM SHALL load a bubble (reg_write_m=0, mem_write_m=0, result_src_m=0, rd_m=0, data 0) when stall_e=1, flush_e=1 (unless in DONE), or valid_e=0 (unless in DONE).
REQ-020 In DONE, EX/MEM SHALL load the MD result, latched rd/reg_write, mem_write_m=0 and result_src_m=0, regardless of valid_e and flush_e.
REQ-021 flush_e during the accept cycle or BUSY SHALL abort the FSM to IDLE at the next edge, with no writeback.
REQ-022 With MD_EN=0, the FSM SHALL stay in IDLE and stall_e SHALL be 0.

Reset
REQ-023 rst=1 SHALL immediately force the FSM to IDLE, the counter and latched operands to 0, and all *_m outputs to 0; stall_e SHALL then follow REQ-015 from current inputs.
REQ-024 rst asserted mid-BUSY SHALL discard the operation, with no later writeback.

Verification
REQ-025 ADD with fwd_a=10, alu_result_m_in=5, rd2=7 -> alu_result_m=12 next edge, rd_m=rd_e.
REQ-026 BLT with A=-1, B=1, branch_e=1, br_funct=100 -> pc_src_e=1, pc_target_e=pc_e+imm_e; with BLTU -> pc_src_e=0.
REQ-027 XLEN=32 MUL 0xFFFF_FFFF*3 -> stall_e high for 33 cycles, bubbles meanwhile, then alu_result_m=0xFFFF_FFFD; MULHU -> 2.
REQ-028 DIVU 7/0 -> 0xFFFF_FFFF; REMU 7/0 -> 7; DIVU 100/7 -> 14 after 33 stall cycles.
REQ-029 flush_e at BUSY cycle 5 -> FSM IDLE next cycle, stall_e=0, reg_write_m never 1 for that instruction.
REQ-030 rst pulse mid-BUSY -> all *_m=0 asynchronously, FSM IDLE, and a following ADD completes in 1 cycle.
